// File: rtl/spi_dac_tx_pkg.sv
// Shared definitions for the MCP4911-class DAC write path: FSM states,
// frame bit layout and a helper that assembles the 16-bit write word.
package spi_dac_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SHIFT,
    ST_CSHI,
    ST_LATCH
  } dacState_e;

  localparam int FRAME_LEN   = 16;
  localparam int DAC_SEL_BIT = 15;
  localparam int CFG_MSB     = 14;
  localparam int CFG_LSB     = 12;
  localparam int DATA_MSB    = 11;
  localparam int DATA_LSB    = 2;

  // Write word: DAC A select, BUF/GA_N/SHDN_N config, 10 data bits, 2 don't-care zeros
  function automatic logic [FRAME_LEN-1:0] buildFrame(input logic bufBit,
                                                      input logic gaN,
                                                      input logic shdnN,
                                                      input logic [9:0] sample);
    logic [FRAME_LEN-1:0] word;
    word                     = '0;
    word[DAC_SEL_BIT]        = 1'b0;
    word[CFG_MSB:CFG_LSB]    = {bufBit, gaN, shdnN};
    word[DATA_MSB:DATA_LSB]  = sample;
    return word;
  endfunction

endpackage

// File: rtl/spi_half_tick.sv
// Half-period prescaler: counts system clocks and raises a one-cycle tick
// every CLK_DIV cycles; restart holds the count at zero so each state
// begins a fresh half period. Also intended for the ADC-side SPI receiver.
module spi_half_tick #(
  parameter int CLK_DIV = 25
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic restart_i,
  output logic tick_o
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] count_q;

  assign tick_o = !restart_i && (count_q == LAST);

  // Free-running count that wraps on every tick and is held clear while restarting
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else if (restart_i || tick_o) begin
      count_q <= '0;
    end else begin
      count_q <= count_q + 1'b1;
    end
  end

endmodule

// File: rtl/spi_dac_tx.sv
// SPI write transmitter for an MCP4911-class DAC. Sends one 16-bit frame per
// sample followed by an LDAC pulse; a single pending slot holds the most
// recent sample requested while a transfer is under way.
module spi_dac_tx
  import spi_dac_tx_pkg::*;
#(
  parameter int CLK_DIV = 25,
  parameter bit BUF     = 1'b1,
  parameter bit GA_N    = 1'b1,
  parameter bit SHDN_N  = 1'b1
) (
  input  logic       sysclk,
  input  logic       rst_n,
  input  logic [9:0] data_in,
  input  logic       load,
  output logic       busy,
  output logic       done,
  output logic       dac_cs_n,
  output logic       dac_sck,
  output logic       dac_sdi,
  output logic       dac_ld_n
);

  dacState_e            state_q;
  logic [FRAME_LEN-1:0] shiftReg_q;
  logic [3:0]           bitCnt_q;
  logic                 phaseLow_q;
  logic                 pendValid_q;
  logic [9:0]           pendData_q;
  logic                 busy_q;
  logic                 done_q;
  logic                 csN_q;
  logic                 sck_q;
  logic                 ldN_q;

  logic                 tick;
  logic                 restart;
  logic [9:0]           startData;
  logic [FRAME_LEN-1:0] startFrame;

  // The prescaler sits cleared in IDLE so SETUP always gets a full half period
  assign restart    = (state_q == ST_IDLE);
  // A waiting sample takes priority over a fresh strobe, which then queues behind it
  assign startData  = pendValid_q ? pendData_q : data_in;
  assign startFrame = buildFrame(BUF, GA_N, SHDN_N, startData);

  spi_half_tick #(
    .CLK_DIV(CLK_DIV)
  ) u_half_tick (
    .clk_i    (sysclk),
    .rst_ni   (rst_n),
    .restart_i(restart),
    .tick_o   (tick)
  );

  // Frame sequencer with registered bus outputs; the MSB of the shift register is the SDI line
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      shiftReg_q  <= '0;
      bitCnt_q    <= '0;
      phaseLow_q  <= 1'b0;
      pendValid_q <= 1'b0;
      pendData_q  <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      csN_q       <= 1'b1;
      sck_q       <= 1'b0;
      ldN_q       <= 1'b1;
    end else begin
      done_q <= 1'b0;

      if (load && (state_q != ST_IDLE)) begin
        pendValid_q <= 1'b1;
        pendData_q  <= data_in;
      end

      case (state_q)
        ST_IDLE: begin
          if (pendValid_q || load) begin
            shiftReg_q  <= startFrame;
            csN_q       <= 1'b0;
            sck_q       <= 1'b0;
            busy_q      <= 1'b1;
            state_q     <= ST_SETUP;
            pendValid_q <= pendValid_q && load;
            if (pendValid_q && load) begin
              pendData_q <= data_in;
            end
          end
        end

        ST_SETUP: begin
          if (tick) begin
            sck_q      <= 1'b1;
            phaseLow_q <= 1'b0;
            bitCnt_q   <= 4'(FRAME_LEN - 1);
            state_q    <= ST_SHIFT;
          end
        end

        ST_SHIFT: begin
          if (tick) begin
            if (!phaseLow_q) begin
              sck_q      <= 1'b0;
              phaseLow_q <= 1'b1;
              if (bitCnt_q != 4'd0) begin
                shiftReg_q <= {shiftReg_q[FRAME_LEN-2:0], 1'b0};
              end
            end else if (bitCnt_q == 4'd0) begin
              csN_q      <= 1'b1;
              shiftReg_q <= '0;
              state_q    <= ST_CSHI;
            end else begin
              bitCnt_q   <= bitCnt_q - 4'd1;
              sck_q      <= 1'b1;
              phaseLow_q <= 1'b0;
            end
          end
        end

        ST_CSHI: begin
          if (tick) begin
            ldN_q   <= 1'b0;
            state_q <= ST_LATCH;
          end
        end

        ST_LATCH: begin
          if (tick) begin
            ldN_q   <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= ST_IDLE;
          end
        end

        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign dac_cs_n = csN_q;
  assign dac_sck  = sck_q;
  assign dac_sdi  = shiftReg_q[FRAME_LEN-1];
  assign dac_ld_n = ldN_q;

endmodule
